// File: rtl/chess_pkg.sv
// Shared chess types for the knight move sequencer: square/board layout,
// piece codes, colours, knight direction offsets and sequencer states.
package chess_pkg;

   typedef enum logic [2:0] {
      PC_NONE   = 3'b000,
      PC_PAWN   = 3'b001,
      PC_KNIGHT = 3'b010,
      PC_BISHOP = 3'b011,
      PC_ROOK   = 3'b100,
      PC_QUEEN  = 3'b101,
      PC_KING   = 3'b110
   } piece_e;

   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   typedef struct packed {
      logic [2:0] ptype;
      logic       color;
      logic       occupied;
   } square_t;

   // board[row][col], row 0 is the top rank
   typedef square_t [7:0][7:0] board_t;

   localparam int NUM_DIRS = 8;
   // Row/col deltas in allow-mask bit order (d = 0..7)
   localparam int DROW [NUM_DIRS] = '{-2, -2, -1,  1,  2,  2,  1, -1};
   localparam int DCOL [NUM_DIRS] = '{-1,  1,  2,  2,  1, -1, -2, -2};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } seq_state_e;

   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      lowest_bit = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest_bit = 3'(i);
      end
   endfunction

endpackage

// File: rtl/knight_move_seq_if.sv
// Move stream from the knight sequencer to the move-list buffer.
// mv_capture exists only when KNIGHT_MOVE_CAPTURE_EN is defined.
interface knight_move_seq_if;
   logic       mv_valid;
   logic       mv_ready;
   logic [2:0] mv_from_row;
   logic [2:0] mv_from_col;
   logic [2:0] mv_to_row;
   logic [2:0] mv_to_col;
`ifdef KNIGHT_MOVE_CAPTURE_EN
   logic       mv_capture;
`endif

   modport master (
      output mv_valid, mv_from_row, mv_from_col, mv_to_row, mv_to_col,
`ifdef KNIGHT_MOVE_CAPTURE_EN
      output mv_capture,
`endif
      input  mv_ready
   );

   modport slave (
      input  mv_valid, mv_from_row, mv_from_col, mv_to_row, mv_to_col,
`ifdef KNIGHT_MOVE_CAPTURE_EN
      input  mv_capture,
`endif
      output mv_ready
   );
endinterface

// File: rtl/knight_targets.sv
// Combinational knight checker for one source square: source match plus
// per-direction legality, target coordinates and target occupancy.
module knight_targets
   import chess_pkg::*;
#(
   parameter logic [2:0] PIECE_CODE = PC_KNIGHT
) (
   input  logic            [2:0] row_i,
   input  logic            [2:0] col_i,
   input  logic                  side_i,
   input  board_t                board_i,
   output logic                  is_piece_o,
   output logic            [7:0] allow_o,
   output logic [7:0]      [2:0] to_row_o,
   output logic [7:0]      [2:0] to_col_o,
   output logic            [7:0] occ_o
);

   square_t src;
   assign src        = board_i[row_i][col_i];
   assign is_piece_o = src.occupied && (src.color == side_i) && (src.ptype == PIECE_CODE);

   for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
      int         r, c;
      logic       on_board;
      logic [2:0] tr, tc;

      assign r        = int'(row_i) + DROW[d];
      assign c        = int'(col_i) + DCOL[d];
      assign on_board = (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
      // Off-board targets collapse to square (0,0) so no index ever wraps
      assign tr       = on_board ? r[2:0] : 3'd0;
      assign tc       = on_board ? c[2:0] : 3'd0;

      assign to_row_o[d] = tr;
      assign to_col_o[d] = tc;
      assign occ_o[d]    = on_board && board_i[tr][tc].occupied;
      assign allow_o[d]  = on_board &&
                           (!board_i[tr][tc].occupied || (board_i[tr][tc].color != side_i));
   end

endmodule

// File: rtl/knight_move_seq.sv
// Scans all 64 squares for knights of the side to move and streams their
// legal moves; KNIGHT_MOVE_CAPTURE_EN adds a registered capture flag.
module knight_move_seq
   import chess_pkg::*;
#(
   parameter logic [2:0] PIECE_CODE = PC_KNIGHT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 side,
   input  board_t               board,
   output logic                 busy,
   output logic                 done,
   output logic           [7:0] move_count,
   knight_move_seq_if.master    mv
);

   seq_state_e       state_q, state_d;
   logic       [5:0] idx_q, idx_d;
   logic       [7:0] mask_q, mask_d;
   logic             side_q, side_d;
   logic       [7:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic       [2:0] fr_row_q, fr_row_d, fr_col_q, fr_col_d;
   logic       [2:0] to_row_q, to_row_d, to_col_q, to_col_d;

   logic             src_match;
   logic       [7:0] allow, tgt_occ;
   logic [7:0] [2:0] tgt_row, tgt_col;
   logic       [2:0] sel, nsel;

   knight_targets #(.PIECE_CODE(PIECE_CODE)) u_targets (
      .row_i      (idx_q[5:3]),
      .col_i      (idx_q[2:0]),
      .side_i     (side_q),
      .board_i    (board),
      .is_piece_o (src_match),
      .allow_o    (allow),
      .to_row_o   (tgt_row),
      .to_col_o   (tgt_col),
      .occ_o      (tgt_occ)
   );

   // mask holds every move of the current knight not yet accepted;
   // its lowest bit is the one on the bus
   assign sel  = lowest_bit(mask_q);
   assign nsel = lowest_bit(mask_d);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      side_d  = side_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               side_d  = side;
               idx_d   = '0;
               mask_d  = '0;
               cnt_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (src_match && (allow != 8'd0)) begin
               mask_d  = allow;
               state_d = S_EMIT;
            end else if (idx_q == 6'd63) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_EMIT: begin
            if (vld_q && mv.mv_ready) begin
               mask_d = mask_q & ~(8'd1 << sel);
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               if (mask_d == 8'd0) begin
                  if (idx_q == 6'd63) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 6'd1;
                     state_d = S_SCAN;
                  end
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Load the bus with the move that will be pending next cycle
      vld_d    = (state_d == S_EMIT);
      fr_row_d = fr_row_q;
      fr_col_d = fr_col_q;
      to_row_d = to_row_q;
      to_col_d = to_col_q;
      if (state_d == S_EMIT) begin
         fr_row_d = idx_q[5:3];
         fr_col_d = idx_q[2:0];
         to_row_d = tgt_row[nsel];
         to_col_d = tgt_col[nsel];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         mask_q   <= '0;
         side_q   <= 1'b0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
         fr_row_q <= '0;
         fr_col_q <= '0;
         to_row_q <= '0;
         to_col_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         mask_q   <= mask_d;
         side_q   <= side_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         fr_row_q <= fr_row_d;
         fr_col_q <= fr_col_d;
         to_row_q <= to_row_d;
         to_col_q <= to_col_d;
      end
   end

`ifdef KNIGHT_MOVE_CAPTURE_EN
   logic cap_q, cap_d;

   always_comb begin
      cap_d = cap_q;
      if (state_d == S_EMIT) cap_d = tgt_occ[nsel];
   end

   always_ff @(posedge clk) begin
      if (reset) cap_q <= 1'b0;
      else       cap_q <= cap_d;
   end

   assign mv.mv_capture = cap_q;
`else
   logic unused_occ;
   assign unused_occ = ^tgt_occ;
`endif

   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign move_count     = cnt_q;
   assign mv.mv_valid    = vld_q;
   assign mv.mv_from_row = fr_row_q;
   assign mv.mv_from_col = fr_col_q;
   assign mv.mv_to_row   = to_row_q;
   assign mv.mv_to_col   = to_col_q;

endmodule

// File: tb/tb_knight_move_seq.sv
// Scoreboard bench for knight_move_seq: a square-by-square reference model
// queues expected moves, a negedge monitor pops and compares accepted moves.
module tb_knight_move_seq;
   import chess_pkg::*;

   logic       clk = 1'b0;
   logic       reset, start, side, busy, done;
   board_t     board;
   logic [7:0] move_count;

   knight_move_seq_if mvif ();

   knight_move_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .side       (side),
      .board      (board),
      .busy       (busy),
      .done       (done),
      .move_count (move_count),
      .mv         (mvif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [12:0] exp_q[$];

   int ptyp [8][8];
   bit pcol [8][8];
   bit pocc [8][8];
   // knight jumps in the required emission order
   int kdr [8] = '{-2, -2, -1, 1, 2, 2, 1, -1};
   int kdc [8] = '{-1, 1, 2, 2, 1, -1, -2, -2};

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic [12:0] cur_mv();
      logic cb;
`ifdef KNIGHT_MOVE_CAPTURE_EN
      cb = mvif.mv_capture;
`else
      cb = 1'b0;
`endif
      return {mvif.mv_from_row, mvif.mv_from_col, mvif.mv_to_row, mvif.mv_to_col, cb};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic [12:0] held;
   bit          hold_v = 0;

   always @(negedge clk) begin
      if (reset) begin
         hold_v = 0;
      end else begin
         if (hold_v && mvif.mv_valid) check("stall_hold", cur_mv(), held);
         hold_v = 0;
         if (mvif.mv_valid && !mvif.mv_ready) begin
            hold_v = 1;
            held   = cur_mv();
         end
         if (mvif.mv_valid && mvif.mv_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_move: got %h expected none", cur_mv());
            end else begin
               check("move", cur_mv(), exp_q.pop_front());
            end
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- board model ----------------
   task automatic clear_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            ptyp[r][c] = 0; pcol[r][c] = 0; pocc[r][c] = 0;
         end
   endtask

   task automatic put(input int r, input int c, input int t, input bit col);
      ptyp[r][c] = t; pcol[r][c] = col; pocc[r][c] = 1;
   endtask

   task automatic apply_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            board[r][c].ptype    = 3'(ptyp[r][c]);
            board[r][c].color    = pcol[r][c];
            board[r][c].occupied = pocc[r][c];
         end
   endtask

   // Expected move list: squares in reading order, jumps in listed order
   task automatic model(input bit s);
      exp_q.delete();
      for (int sq = 0; sq < 64; sq++) begin
         int r, c;
         r = sq / 8;
         c = sq % 8;
         if (pocc[r][c] && pcol[r][c] == s && ptyp[r][c] == 2) begin
            for (int d = 0; d < 8; d++) begin
               int tr, tc;
               bit cb;
               tr = r + kdr[d];
               tc = c + kdc[d];
               if (tr >= 0 && tr < 8 && tc >= 0 && tc < 8) begin
                  if (!pocc[tr][tc] || pcol[tr][tc] != s) begin
`ifdef KNIGHT_MOVE_CAPTURE_EN
                     cb = pocc[tr][tc];
`else
                     cb = 1'b0;
`endif
                     exp_q.push_back({3'(r), 3'(c), 3'(tr), 3'(tc), cb});
                  end
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rmode: 0 ready held high, 1 ready toggles 1-0-1, 2 random ready
   task automatic run_scan(input bit s, input int rmode, input bit busy_start, input int want_done);
      int n, d0, nexp;
      model(s);
      nexp = exp_q.size();
      d0   = done_cnt;
      side = s;
      start = 1'b1;
      mvif.mv_ready = 1'b1;
      step();
      start = 1'b0;
      side  = ~s;
      check("busy_after_start", busy, 1);
      n = 0;
      while (!done && n < 4000) begin
         case (rmode)
            0:       mvif.mv_ready = 1'b1;
            1:       mvif.mv_ready = (n % 2 == 0);
            default: mvif.mv_ready = 1'($urandom_range(0, 1));
         endcase
         start = busy_start && (n == 5);
         step();
         n++;
      end
      start = 1'b0;
      check("done_seen", done, 1);
      if (want_done >= 0) check("done_cycle", n, want_done);
      check("move_count", move_count, (nexp > 255) ? 255 : nexp);
      step();
      check("busy_fall", busy, 0);
      check("done_fall", done, 0);
      check("queue_drained", exp_q.size(), 0);
      check("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      int n, d0;
      reset = 1'b1; start = 1'b0; side = 1'b0; board = '0; mvif.mv_ready = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", mvif.mv_valid, 0);
      check("rst_count", move_count, 0);
      check("rst_from", {mvif.mv_from_row, mvif.mv_from_col}, 0);
      check("rst_to", {mvif.mv_to_row, mvif.mv_to_col}, 0);
`ifdef KNIGHT_MOVE_CAPTURE_EN
      check("rst_capture", mvif.mv_capture, 0);
`endif
      reset = 1'b0;
      step();

      // corner-side white knight, free board
      clear_board(); put(7, 1, 2, WHITE); apply_board();
      run_scan(WHITE, 0, 0, -1);

      // black corner knight with own and enemy blockers
      clear_board(); put(0, 0, 2, BLACK); put(2, 1, 1, BLACK); put(1, 2, 1, WHITE); apply_board();
      run_scan(BLACK, 0, 0, -1);

      // no knight of the side to move: pure scan timing
      clear_board(); put(3, 3, 2, WHITE); put(5, 6, 3, BLACK); apply_board();
      run_scan(BLACK, 0, 0, 64);

      // centre knight with toggling ready
      clear_board(); put(4, 4, 2, WHITE); apply_board();
      run_scan(WHITE, 1, 0, -1);

      // start pulsed while busy is ignored
      clear_board(); put(7, 1, 2, WHITE); put(0, 6, 2, WHITE); apply_board();
      run_scan(WHITE, 2, 1, -1);

      // reset while a move is pending
      clear_board(); put(4, 4, 2, WHITE); apply_board();
      exp_q.delete();
      side = WHITE; start = 1'b1; mvif.mv_ready = 1'b0;
      step();
      start = 1'b0;
      n = 0;
      while (!mvif.mv_valid && n < 200) begin step(); n++; end
      check("reach_emit", mvif.mv_valid, 1);
      d0 = done_cnt;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", mvif.mv_valid, 0);
      check("abort_count", move_count, 0);
      check("abort_coords", {mvif.mv_from_row, mvif.mv_from_col, mvif.mv_to_row, mvif.mv_to_col}, 0);
      repeat (80) step();
      check("abort_no_done", done_cnt - d0, 0);
      run_scan(WHITE, 0, 0, -1);

      // random boards against the model
      for (int it = 0; it < 8; it++) begin
         bit s;
         clear_board();
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               if ($urandom_range(0, 99) < 30)
                  put(r, c, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 3; k++)
            put($urandom_range(0, 7), $urandom_range(0, 7), 2, 1'($urandom_range(0, 1)));
         apply_board();
         s = 1'($urandom_range(0, 1));
         run_scan(s, 2, (it % 2) == 1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/knight_move_seq.md
# knight_move_seq

Sequencer that walks all 64 board squares, finds every knight belonging to the side to move, and streams each legal knight destination as a from/to move over a valid/ready interface. It sits between the game-control FSM (which issues `start` once per turn) and the move-list buffer. It owns the single combinational knight-target checker and time-multiplexes it across squares.

## Interface
- `PIECE_CODE`, default 3'b010: piece-type field value identifying a knight.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `side`  in  1  side to move (0 white, 1 black); latched on accepted `start`.
- `board`  in  `board_t` (8x8x5)  square = {type[4:2], color[1], occupied[0]}; must be held stable while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` through DONE.
- `done`  out  1  one-cycle pulse when the scan completes.
- `mv_valid`  out  1  a move is presented.
- `mv_ready`  in  1  consumer accepts the move this cycle.
- `mv_from_row`, `mv_from_col`, `mv_to_row`, `mv_to_col`  out  3 each  move coordinates; row 0 is the top of the board.
- `move_count`  out  8  moves accepted this scan; saturates at 255; cleared on accepted `start`.

## Operation
- **Direction index d (bit order of the 8-bit allow mask):**
  - 0 = up2/left1, 1 = up2/right1, 2 = right2/up1, 3 = right2/down1.
  - 4 = down2/right1, 5 = down2/left1, 6 = left2/down1, 7 = left2/up1.
- **Allow rule:** a target is allowed iff it is on the board AND (the target square is empty OR its color != `side`).
  - Off-board targets are rejected before any board index is formed; indices never wrap.
- **FSM states:** IDLE, SCAN, EMIT, DONE.
- **IDLE:** `start` latches `side`, clears `idx` (6-bit square index, idx = row*8+col), clears `move_count`, and moves to SCAN.
- **SCAN:** examine square `idx`.
  - If it is occupied, color==`side` and type==`PIECE_CODE`, latch the allow mask.
  - Nonzero mask → EMIT.
  - Otherwise, if idx==63 → DONE; else idx+1 and stay in SCAN.
- **EMIT:**
  - `mv_valid`=1; the lowest set mask bit selects the presented move.
  - On `mv_valid & mv_ready`: clear that bit and increment `move_count`.
  - When the last bit clears: go to DONE if idx==63; else idx+1 and return to SCAN.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- **Reset values:**
  - State IDLE, idx 0, mask 0.
  - `busy`, `done`, `mv_valid` 0; `move_count` 0; all coordinates 0.
- Reset in any state (including mid-EMIT with a move pending) aborts the scan; no `done` pulse follows.

## Timing
- **Start:** `start` sampled at cycle 0 → SCAN at cycle 1 examining square 0; `busy` high from cycle 1.
- **Cost per square:**
  - Non-matching square: 1 cycle.
  - Matching square: 1 SCAN cycle + one EMIT cycle per accepted move (with no backpressure).
- **Empty scan:** a board with no matching knights gives SCAN on cycles 1–64 and `done` on cycle 65.
- **Output stability:** the `mv_*` outputs are registered and stay stable while `mv_valid & !mv_ready`.
- **Back-to-back moves:** consecutive moves from the same knight are presented on consecutive cycles when `mv_ready` is held high.
- **Completion:** `done` and `busy` fall together on the cycle after DONE.

## Configuration
- **`KNIGHT_MOVE_CAPTURE_EN` defined:** adds output `mv_capture` (1 bit), registered alongside the move.
  - `mv_capture`=1 iff the target square is occupied.
  - Reset value 0.
- **Not defined:** port absent; all other behaviour identical.

## Structure
- **Package `chess_pkg`:**
  - `square_t` (5-bit packed struct) and `board_t`.
  - `piece_e` (000 none, 001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king).
  - Color constants `WHITE`=0, `BLACK`=1.
  - Direction offset tables for d=0..7.
- **Sub-module `knight_targets`** (combinational), instanced once:
  - Inputs: row, col, side, board.
  - Outputs: 8-bit allow mask, per-direction target coordinates, per-direction occupied flags.
  - Holds the allow rule above.

## Test plan
- Empty board, white knight at (7,1), side=0, `mv_ready`=1 → moves (7,1)→(5,0), (5,2), (6,3) in that order; `move_count`=3; `done` once.
- Black knight at (0,0), black piece at (2,1), white piece at (1,2), side=1 → one move (0,0)→(1,2); with `KNIGHT_MOVE_CAPTURE_EN`, `mv_capture`=1.
- No knights of `side` present → `mv_valid` never asserts; `done` on cycle 65 after `start`; `move_count`=0.
- Knight at (4,4) on an empty board, `mv_ready` toggled 1-0-1 → 8 moves in d order 0..7; outputs held while stalled; no duplicates or drops.
- `reset` asserted mid-EMIT → next cycle IDLE, all outputs 0, no `done`; a new `start` rescans from square 0.
- `start` pulsed while `busy` → ignored; `move_count` and `idx` unaffected.
